game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 166 ++++++++++++++++
 tb/tb_game_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Game controller: IDLE/RUN/DYING/OVER sequencing, frame-tick scoring,
// speed ramp, sprite page animation and death blink for the runner game.
module game_ctrl #(
   parameter logic [7:0] KEY_JUMP    = 8'h2C,
   parameter logic [7:0] KEY_RESTART = 8'h28,
   parameter int         DIE_FRAMES  = 30,
   parameter int         SPEED_INIT  = 2,
   parameter int         SPEED_MAX   = 8
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frame_clk,
   input  logic [7:0]  keycode,
   input  logic        collision,
   output logic [1:0]  state,
   output logic        run_en,
   output logic        jump_req,
   output logic [3:0]  page_idx,
   output logic [15:0] score,
   output logic [3:0]  speed,
   output logic        flash
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_DYING = 2'b10,
      S_OVER  = 2'b11
   } state_t;

   localparam logic [3:0] SP_INIT  = 4'(SPEED_INIT);
   localparam logic [3:0] SP_MAX   = 4'(SPEED_MAX);
   localparam logic [7:0] DIE_LAST = 8'(DIE_FRAMES - 1);

   state_t      r_state;
   logic        r_frame_d;
   logic        r_tick;
   logic [7:0]  r_key_d;
   logic        r_key_vld;
   logic        r_coll;
   logic [15:0] r_score;
   logic [3:0]  r_speed;
   logic [4:0]  r_half;
   logic [7:0]  r_die;
   logic        r_flash;
   logic        r_jump;

   logic        w_tick_raw;
   logic        w_press_jump;
   logic        w_press_restart;
   state_t      w_state_nxt;
   logic        w_coll_nxt;
   logic [15:0] w_score_nxt;
   logic [3:0]  w_speed_nxt;
   logic [4:0]  w_half_nxt;
   logic [7:0]  w_die_nxt;
   logic        w_flash_nxt;
   logic        w_jump_nxt;

   function automatic logic [15:0] sat_inc_score(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [3:0] sat_inc_speed(input logic [3:0] v);
      return (v >= SP_MAX) ? SP_MAX : v + 4'd1;
   endfunction

   assign w_tick_raw = frame_clk & ~r_frame_d;

   // r_key_vld blocks a key already held when reset releases from counting as a press
   assign w_press_jump    = r_key_vld && (keycode == KEY_JUMP)    && (r_key_d != KEY_JUMP);
   assign w_press_restart = r_key_vld && (keycode == KEY_RESTART) && (r_key_d != KEY_RESTART);

   always_comb begin
      w_state_nxt = r_state;
      w_coll_nxt  = 1'b0;
      w_score_nxt = r_score;
      w_speed_nxt = r_speed;
      w_half_nxt  = r_half;
      w_die_nxt   = r_die;
      w_jump_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_press_jump) begin
               w_state_nxt = S_RUN;
               w_score_nxt = 16'd0;
               w_speed_nxt = SP_INIT;
               w_half_nxt  = 5'd0;
            end
         end
         S_RUN: begin
            w_coll_nxt = r_tick ? 1'b0 : (r_coll | collision);
            if (r_tick && (r_coll || collision)) begin
               // death wins over a simultaneous jump press
               w_state_nxt = S_DYING;
               w_die_nxt   = 8'd0;
            end else begin
               w_jump_nxt = w_press_jump;
               if (r_tick) begin
                  w_score_nxt = sat_inc_score(r_score);
                  if (r_score[7:0] == 8'hFF && r_score != 16'hFFFF)
                     w_speed_nxt = sat_inc_speed(r_speed);
                  w_half_nxt = (r_half == 5'd17) ? 5'd0 : r_half + 5'd1;
               end
            end
         end
         S_DYING: begin
            if (r_tick) begin
               if (r_die == DIE_LAST)
                  w_state_nxt = S_OVER;
               else
                  w_die_nxt = r_die + 8'd1;
            end
         end
         S_OVER: begin
            if (w_press_restart) begin
               w_state_nxt = S_IDLE;
               w_score_nxt = 16'd0;
               w_speed_nxt = SP_INIT;
               w_half_nxt  = 5'd0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_flash_nxt = (w_state_nxt == S_DYING) && w_die_nxt[2];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= S_IDLE;
         r_frame_d <= 1'b0;
         r_tick    <= 1'b0;
         r_key_d   <= 8'd0;
         r_key_vld <= 1'b0;
         r_coll    <= 1'b0;
         r_score   <= 16'd0;
         r_speed   <= SP_INIT;
         r_half    <= 5'd0;
         r_die     <= 8'd0;
         r_flash   <= 1'b0;
         r_jump    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_frame_d <= frame_clk;
         r_tick    <= w_tick_raw;
         r_key_d   <= keycode;
         r_key_vld <= 1'b1;
         r_coll    <= w_coll_nxt;
         r_score   <= w_score_nxt;
         r_speed   <= w_speed_nxt;
         r_half    <= w_half_nxt;
         r_die     <= w_die_nxt;
         r_flash   <= w_flash_nxt;
         r_jump    <= w_jump_nxt;
      end
   end

   assign state    = r_state;
   assign run_en   = (r_state == S_RUN);
   assign jump_req = r_jump;
   assign page_idx = r_half[4:1];
   assign score    = r_score;
   assign speed    = r_speed;
   assign flash    = r_flash;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: expectations are queued as stimulus is
// applied and compared against the DUT outputs when they are sampled.
`timescale 1ns/1ps
module tb_game_ctrl;

   logic        Clk;
   logic        Reset_n;
   logic        frame_clk;
   logic [7:0]  keycode;
   logic        collision;
   logic [1:0]  state;
   logic        run_en;
   logic        jump_req;
   logic [3:0]  page_idx;
   logic [15:0] score;
   logic [3:0]  speed;
   logic        flash;

   game_ctrl dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .frame_clk (frame_clk),
      .keycode   (keycode),
      .collision (collision),
      .state     (state),
      .run_en    (run_en),
      .jump_req  (jump_req),
      .page_idx  (page_idx),
      .score     (score),
      .speed     (speed),
      .flash     (flash)
   );

   localparam int SEL_STATE = 0, SEL_RUN = 1, SEL_JUMP = 2, SEL_PAGE = 3;
   localparam int SEL_SCORE = 4, SEL_SPEED = 5, SEL_FLASH = 6, SEL_JCNT = 7;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   jcnt     = 0;
   int   jbase    = 0;

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   // count Clk cycles with jump_req high
   always @(negedge Clk) if (jump_req === 1'b1) jcnt <= jcnt + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         SEL_STATE: return 32'(state);
         SEL_RUN:   return 32'(run_en);
         SEL_JUMP:  return 32'(jump_req);
         SEL_PAGE:  return 32'(page_idx);
         SEL_SCORE: return 32'(score);
         SEL_SPEED: return 32'(speed);
         SEL_FLASH: return 32'(flash);
         default:   return 32'(jcnt - jbase);
      endcase
   endfunction

   task automatic expect_val(input string tag, input int sel, input logic [31:0] e);
      exp_t t;
      t.tag = tag;
      t.sel = sel;
      t.exp = e;
      sb_q.push_back(t);
   endtask

   task automatic drain();
      exp_t t;
      while (sb_q.size() > 0) begin
         t = sb_q.pop_front();
         check_val(t.tag, observe(t.sel), t.exp);
      end
   endtask

   task automatic expect_reset_vals(input string tag);
      expect_val({tag, "_state"}, SEL_STATE, 0);
      expect_val({tag, "_run_en"}, SEL_RUN, 0);
      expect_val({tag, "_jump"}, SEL_JUMP, 0);
      expect_val({tag, "_page"}, SEL_PAGE, 0);
      expect_val({tag, "_score"}, SEL_SCORE, 0);
      expect_val({tag, "_speed"}, SEL_SPEED, 2);
      expect_val({tag, "_flash"}, SEL_FLASH, 0);
   endtask

   task automatic do_tick();
      @(negedge Clk) frame_clk = 1'b1;
      @(negedge Clk) frame_clk = 1'b0;
      @(negedge Clk);
   endtask

   task automatic key(input logic [7:0] k, input int cycles);
      @(negedge Clk) keycode = k;
      repeat (cycles) @(negedge Clk);
   endtask

   int mhalf;
   int mdie;
   int mst;

   initial begin
      Reset_n   = 1'b0;
      frame_clk = 1'b0;
      keycode   = 8'h2C;
      collision = 1'b0;
      repeat (3) @(negedge Clk);
      expect_reset_vals("reset");
      drain();

      // release reset with the jump key already held
      Reset_n = 1'b1;
      repeat (3) @(negedge Clk);
      expect_val("held_key_idle", SEL_STATE, 0);
      drain();

      key(8'h00, 2);
      jbase = jcnt;
      key(8'h2C, 3);
      expect_val("start_state", SEL_STATE, 1);
      expect_val("start_run_en", SEL_RUN, 1);
      expect_val("start_no_jump", SEL_JCNT, 0);
      expect_val("start_score", SEL_SCORE, 0);
      expect_val("start_speed", SEL_SPEED, 2);
      expect_val("start_page", SEL_PAGE, 0);
      drain();

      key(8'h00, 2);
      jbase = jcnt;
      key(8'h2C, 4);
      expect_val("jump_pulse_width", SEL_JCNT, 1);
      drain();
      key(8'h00, 2);

      // 300 frames in RUN with page animation tracked per frame
      mhalf = 0;
      for (int i = 1; i <= 300; i++) begin
         do_tick();
         mhalf = (mhalf == 17) ? 0 : mhalf + 1;
         expect_val($sformatf("page_t%0d", i), SEL_PAGE, 32'(mhalf >> 1));
         drain();
      end
      expect_val("score_300", SEL_SCORE, 300);
      expect_val("speed_300", SEL_SPEED, 3);
      drain();

      // single-Clk collision between frames is remembered until the next tick
      @(negedge Clk) collision = 1'b1;
      @(negedge Clk) collision = 1'b0;
      repeat (2) @(negedge Clk);
      expect_val("coll_wait_run", SEL_STATE, 1);
      drain();
      do_tick();
      expect_val("die_state", SEL_STATE, 2);
      expect_val("die_run_en", SEL_RUN, 0);
      expect_val("die_score", SEL_SCORE, 300);
      expect_val("die_flash0", SEL_FLASH, 0);
      drain();

      key(8'h28, 2);
      expect_val("dying_ignores_key", SEL_STATE, 2);
      drain();
      key(8'h00, 1);

      mdie = 0;
      mst  = 2;
      for (int k = 1; k <= 30; k++) begin
         do_tick();
         if (mdie == 29) mst = 3;
         else mdie = mdie + 1;
         expect_val($sformatf("dying_state_t%0d", k), SEL_STATE, 32'(mst));
         expect_val($sformatf("flash_t%0d", k), SEL_FLASH, (mst == 2) ? 32'((mdie >> 2) & 1) : 0);
         drain();
      end
      expect_val("over_score", SEL_SCORE, 300);
      expect_val("over_speed", SEL_SPEED, 3);
      drain();

      key(8'h2C, 2);
      expect_val("over_ignores_jump", SEL_STATE, 3);
      expect_val("over_hold_score", SEL_SCORE, 300);
      drain();
      key(8'h00, 2);
      key(8'h28, 2);
      expect_val("restart_state", SEL_STATE, 0);
      expect_val("restart_score", SEL_SCORE, 0);
      expect_val("restart_speed", SEL_SPEED, 2);
      expect_val("restart_page", SEL_PAGE, 0);
      drain();
      key(8'h00, 2);

      // collision and jump press land on the same tick Clk
      key(8'h2C, 2);
      expect_val("rerun_state", SEL_STATE, 1);
      drain();
      key(8'h00, 2);
      repeat (3) do_tick();
      expect_val("rerun_score", SEL_SCORE, 3);
      drain();
      jbase = jcnt;
      @(negedge Clk) frame_clk = 1'b1;
      @(negedge Clk) begin
         frame_clk = 1'b0;
         collision = 1'b1;
         keycode   = 8'h2C;
      end
      @(negedge Clk) collision = 1'b0;
      repeat (3) @(negedge Clk);
      expect_val("simul_state", SEL_STATE, 2);
      expect_val("simul_no_jump", SEL_JCNT, 0);
      expect_val("simul_score", SEL_SCORE, 3);
      drain();

      // asynchronous reset mid-DYING, then mid-RUN
      @(posedge Clk);
      #5 Reset_n = 1'b0;
      #1 expect_reset_vals("rst_dying");
      drain();
      @(negedge Clk) Reset_n = 1'b1;
      key(8'h00, 2);
      key(8'h2C, 2);
      key(8'h00, 1);
      repeat (5) do_tick();
      expect_val("run5_state", SEL_STATE, 1);
      expect_val("run5_score", SEL_SCORE, 5);
      expect_val("run5_page", SEL_PAGE, 2);
      drain();
      @(posedge Clk);
      #5 Reset_n = 1'b0;
      #1 expect_reset_vals("rst_run");
      drain();
      @(negedge Clk) Reset_n = 1'b1;
      repeat (2) @(negedge Clk);
      expect_val("post_rst_idle", SEL_STATE, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
